// File: rtl/dram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_req_arbiter
// Purpose  : Round-robin arbiter serialising NUM_REQ requesters onto a single
//            DRAM controller command port, one transaction in flight.
// Options  : define ARB_ROW_HIT_PRIO_EN to favour requesters hitting the last
//            issued bank/row (capped at 4 consecutive hit grants).
// Revision : 1.0 - initial release
// ============================================================================
module dram_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int U_ADDR_WIDTH = 12,
    parameter int U_DATA_WIDTH = 2
) (
    input  logic                             u_clk,
    input  logic                             u_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_cmd,
    input  logic [NUM_REQ*U_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*U_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [U_DATA_WIDTH-1:0]          req_rdata,
    output logic                             arb_busy,
    output logic                             ctrl_en,
    output logic                             ctrl_cmd,
    output logic [U_ADDR_WIDTH-1:0]          ctrl_addr,
    output logic [U_DATA_WIDTH-1:0]          ctrl_wdata,
    input  logic                             ctrl_busy,
    input  logic                             ctrl_data_valid,
    input  logic                             ctrl_refresh_done,
    input  logic [U_DATA_WIDTH-1:0]          ctrl_data_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_EXEC   = 2'd2,
        ARB_RDWAIT = 2'd3
    } arb_state_t;

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          win_q, win_d;
    logic                      ctrl_cmd_q, ctrl_cmd_d;
    logic [U_ADDR_WIDTH-1:0]   ctrl_addr_q, ctrl_addr_d;
    logic [U_DATA_WIDTH-1:0]   ctrl_wdata_q, ctrl_wdata_d;
    logic [U_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]        rd_done_q, rd_done_d;

    logic [U_ADDR_WIDTH-1:0]   req_addr_a  [NUM_REQ];
    logic [U_DATA_WIDTH-1:0]   req_wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0]        elig;
    logic                      grant_found;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_en;
    logic [NUM_REQ-1:0]        ack_c;
    logic [NUM_REQ-1:0]        wr_done_c;
    logic                      en_c;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_a[gi]  = req_addr[gi*U_ADDR_WIDTH +: U_ADDR_WIDTH];
            assign req_wdata_a[gi] = req_wdata[gi*U_DATA_WIDTH +: U_DATA_WIDTH];
        end
    endgenerate

    // First set bit of mask at or after ptr (circular); MSB of result = found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        int               pos;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = IDX_W'(pos);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // A requester whose read completion is being reported this cycle sits out
    // one arbitration so ack and done never coincide on the same port.
    assign elig = req_valid & ~rd_done_q;

`ifdef ARB_ROW_HIT_PRIO_EN
    localparam int              BR_W      = U_ADDR_WIDTH - 2;
    localparam logic [2:0]      HIT_LIMIT = 3'd4;

    logic [BR_W-1:0]            last_br_q, last_br_d;
    logic                       last_vld_q, last_vld_d;
    logic [2:0]                 hit_cnt_q, hit_cnt_d;
    logic [NUM_REQ-1:0]         hit_mask;
    logic [IDX_W:0]             pick_rr, pick_hit, pick_miss;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit
            assign hit_mask[gi] = last_vld_q &&
                                  (req_addr_a[gi][U_ADDR_WIDTH-1:2] == last_br_q);
        end
    endgenerate

    // Once the hit streak is capped, a non-hit requester takes the grant so
    // the streak is really broken.
    always_comb begin
        pick_rr   = rr_pick(elig, rr_ptr_q);
        pick_hit  = rr_pick(elig & hit_mask, rr_ptr_q);
        pick_miss = rr_pick(elig & ~hit_mask, rr_ptr_q);
        if (pick_hit[IDX_W] && (hit_cnt_q < HIT_LIMIT)) begin
            {grant_found, grant_idx} = pick_hit;
        end else if ((hit_cnt_q == HIT_LIMIT) && pick_miss[IDX_W]) begin
            {grant_found, grant_idx} = pick_miss;
        end else begin
            {grant_found, grant_idx} = pick_rr;
        end
    end

    always_comb begin
        last_br_d  = last_br_q;
        last_vld_d = last_vld_q;
        hit_cnt_d  = hit_cnt_q;
        if (grant_en) begin
            last_br_d  = req_addr_a[grant_idx][U_ADDR_WIDTH-1:2];
            last_vld_d = 1'b1;
            if (hit_mask[grant_idx]) begin
                hit_cnt_d = (hit_cnt_q == HIT_LIMIT) ? HIT_LIMIT : hit_cnt_q + 3'd1;
            end else begin
                hit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            last_br_q  <= '0;
            last_vld_q <= 1'b0;
            hit_cnt_q  <= '0;
        end else begin
            last_br_q  <= last_br_d;
            last_vld_q <= last_vld_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end
`else
    always_comb begin
        {grant_found, grant_idx} = rr_pick(elig, rr_ptr_q);
    end
`endif

    assign grant_en = (state_q == ARB_IDLE) && grant_found && !ctrl_busy;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        ctrl_cmd_d   = ctrl_cmd_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdata_d = ctrl_wdata_q;
        rdata_d      = rdata_q;
        rd_done_d    = '0;
        ack_c        = '0;
        wr_done_c    = '0;
        en_c         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_en) begin
                    ack_c        = NUM_REQ'(1) << grant_idx;
                    win_d        = grant_idx;
                    ctrl_cmd_d   = req_cmd[grant_idx];
                    ctrl_addr_d  = req_addr_a[grant_idx];
                    ctrl_wdata_d = req_wdata_a[grant_idx];
                    rr_ptr_d     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + 1'b1;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                en_c = 1'b1;
                if (!ctrl_refresh_done && ctrl_busy) state_d = ARB_EXEC;
            end
            ARB_EXEC: begin
                en_c = ctrl_busy;
                // A refresh occupied the busy window: re-issue the latched command.
                if (ctrl_refresh_done) begin
                    state_d = ARB_ISSUE;
                end else if (!ctrl_busy) begin
                    if (ctrl_cmd_q) begin
                        wr_done_c = NUM_REQ'(1) << win_q;
                        state_d   = ARB_IDLE;
                    end else begin
                        state_d   = ARB_RDWAIT;
                    end
                end
            end
            ARB_RDWAIT: begin
                if (ctrl_data_valid) begin
                    rdata_d   = ctrl_data_o;
                    rd_done_d = NUM_REQ'(1) << win_q;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            ctrl_cmd_q   <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            rdata_q      <= '0;
            rd_done_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            ctrl_cmd_q   <= ctrl_cmd_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            rdata_q      <= rdata_d;
            rd_done_q    <= rd_done_d;
        end
    end

    // Combinational pulses are masked while reset is asserted so nothing
    // is acknowledged or completed in a cycle that reset discards.
    assign req_ack    = ack_c & {NUM_REQ{~u_rst}};
    assign req_done   = (wr_done_c & {NUM_REQ{~u_rst}}) | rd_done_q;
    assign ctrl_en    = en_c & ~u_rst;
    assign req_rdata  = rdata_q;
    assign arb_busy   = (state_q != ARB_IDLE);
    assign ctrl_cmd   = ctrl_cmd_q;
    assign ctrl_addr  = ctrl_addr_q;
    assign ctrl_wdata = ctrl_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_req_arbiter
// Purpose  : Scoreboard bench for dram_req_arbiter (grants, completions,
//            refresh re-issue, reset abandonment, optional row-hit priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 2;

    logic              u_clk = 1'b0;
    logic              u_rst;
    logic [NR-1:0]     req_valid, req_cmd;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ack, req_done;
    logic [DW-1:0]     req_rdata;
    logic              arb_busy, ctrl_en, ctrl_cmd;
    logic [AW-1:0]     ctrl_addr;
    logic [DW-1:0]     ctrl_wdata;
    logic              ctrl_busy, ctrl_data_valid, ctrl_refresh_done;
    logic [DW-1:0]     ctrl_data_o;

    dram_req_arbiter #(.NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW)) dut (
        .u_clk(u_clk), .u_rst(u_rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_done(req_done), .req_rdata(req_rdata), .arb_busy(arb_busy),
        .ctrl_en(ctrl_en), .ctrl_cmd(ctrl_cmd), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_busy(ctrl_busy), .ctrl_data_valid(ctrl_data_valid),
        .ctrl_refresh_done(ctrl_refresh_done), .ctrl_data_o(ctrl_data_o)
    );

    always #5 u_clk = ~u_clk;

    typedef struct {
        int          idx;
        bit          rd;
        logic [DW-1:0] val;
    } done_t;

    int            ack_q[$];
    done_t         done_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] cfg_addr [NR];
    logic [DW-1:0] cfg_wd   [NR];
    bit            cfg_rd   [NR];

    int rr_order[5] = '{0, 1, 2, 3, 0};
`ifdef ARB_ROW_HIT_PRIO_EN
    int hit_order[5] = '{3, 1, 3, 1, 0};
`else
    int hit_order[5] = '{3, 0, 1, 3, 0};
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every ack/done pulse must match the oldest pending expectation.
    always @(negedge u_clk) begin
        if (req_ack != '0) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(req_ack), 32'd0);
            end else begin
                int e;
                e = ack_q.pop_front();
                check("ack_onehot", 32'(req_ack), 32'd1 << e);
            end
        end
        if (req_done != '0) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(req_done), 32'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_onehot", 32'(req_done), 32'd1 << d.idx);
                if (d.rd) check("done_rdata", 32'(req_rdata), 32'(d.val));
            end
        end
    end

    task automatic nxt();
        @(posedge u_clk);
        #1;
    endtask

    task automatic drain();
        @(negedge u_clk);
        #1;
        check("ack_late", ack_q.size(), 0);
        check("done_late", done_q.size(), 0);
    endtask

    task automatic set_req(input int i, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        cfg_addr[i]            = a;
        cfg_wd[i]              = wd;
        cfg_rd[i]              = rd;
        req_cmd[i]             = ~rd;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = wd;
    endtask

    task automatic do_reset();
        u_rst             = 1'b1;
        req_valid         = '0;
        ctrl_busy         = 1'b0;
        ctrl_data_valid   = 1'b0;
        ctrl_refresh_done = 1'b0;
        nxt();
        nxt();
        u_rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ack"},   32'(req_ack),    0);
        check({pfx, "_done"},  32'(req_done),   0);
        check({pfx, "_rdata"}, 32'(req_rdata),  0);
        check({pfx, "_busy"},  32'(arb_busy),   0);
        check({pfx, "_en"},    32'(ctrl_en),    0);
        check({pfx, "_cmd"},   32'(ctrl_cmd),   0);
        check({pfx, "_addr"},  32'(ctrl_addr),  0);
        check({pfx, "_wdata"}, 32'(ctrl_wdata), 0);
    endtask

    // Entered at the IDLE cycle where the grant is expected; returns at the
    // next IDLE cycle (after the read-done edge for reads).
    task automatic run_txn(input int idx, input int busy_n, input bit refresh,
                           input logic [DW-1:0] rdv, input bit drop, input bit rst_rdwait);
        bit    rd;
        done_t d;
        rd = cfg_rd[idx];
        ack_q.push_back(idx);
        drain();
        check("idle_busy", 32'(arb_busy), 0);
        nxt();
        if (drop) req_valid[idx] = 1'b0;
        check("issue_en",   32'(ctrl_en), 1);
        check("issue_addr", 32'(ctrl_addr), 32'(cfg_addr[idx]));
        check("issue_cmd",  32'(ctrl_cmd), 32'(!rd));
        if (!rd) check("issue_wdata", 32'(ctrl_wdata), 32'(cfg_wd[idx]));
        check("issue_busy", 32'(arb_busy), 1);
        ctrl_busy = 1'b1;
        if (refresh) begin
            nxt();
            ctrl_refresh_done = 1'b1;
            #1 check("exec_en_refresh", 32'(ctrl_en), 1);
            nxt();
            ctrl_refresh_done = 1'b0;
            #1 check("reissue_en", 32'(ctrl_en), 1);
            check("reissue_addr", 32'(ctrl_addr), 32'(cfg_addr[idx]));
        end
        for (int k = 1; k < busy_n; k++) begin
            nxt();
            check("exec_en", 32'(ctrl_en), 1);
        end
        nxt();
        ctrl_busy = 1'b0;
        if (!rd) begin
            d.idx = idx; d.rd = 1'b0; d.val = '0;
            done_q.push_back(d);
        end
        #1 check("en_fall", 32'(ctrl_en), 0);
        drain();
        nxt();
        if (rd) begin
            check("rdwait_en", 32'(ctrl_en), 0);
            ctrl_data_valid = 1'b1;
            ctrl_data_o     = rdv;
            if (rst_rdwait) begin
                u_rst     = 1'b1;
                req_valid = '0;
                nxt();
                u_rst           = 1'b0;
                ctrl_data_valid = 1'b0;
                #1 check_reset_outputs("rst_rdwait");
            end else begin
                d.idx = idx; d.rd = 1'b1; d.val = rdv;
                done_q.push_back(d);
                nxt();
                ctrl_data_valid = 1'b0;
                check("rdata_hold", 32'(req_rdata), 32'(rdv));
            end
        end
    endtask

    initial begin
        u_rst = 1'b1; req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        ctrl_busy = 1'b0; ctrl_data_valid = 1'b0; ctrl_refresh_done = 1'b0; ctrl_data_o = '0;
        do_reset();
        check_reset_outputs("reset");

        // Single write, three busy cycles.
        set_req(0, 1'b0, 12'h045, 2'b10);
        req_valid = 4'b0001;
        run_txn(0, 3, 1'b0, 2'b00, 1'b1, 1'b0);

        // All requesters held, pointer freshly reset.
        do_reset();
        set_req(0, 1'b0, 12'h111, 2'b01);
        set_req(1, 1'b0, 12'h222, 2'b10);
        set_req(2, 1'b0, 12'h333, 2'b11);
        set_req(3, 1'b0, 12'h3A7, 2'b00);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) run_txn(rr_order[i], 1, 1'b0, 2'b00, 1'b0, 1'b0);
        req_valid = '0;

        // Controller busy in IDLE blocks the grant, then a read from requester 2.
        set_req(2, 1'b1, 12'h5C8, 2'b00);
        ctrl_busy = 1'b1;
        req_valid = 4'b0100;
        @(negedge u_clk); #1;
        check("busy_block_ack", 32'(req_ack), 0);
        nxt();
        check("busy_block_state", 32'(arb_busy), 0);
        ctrl_busy = 1'b0;
        run_txn(2, 2, 1'b0, 2'b01, 1'b1, 1'b0);

        // Refresh during EXEC forces a re-issue.
        set_req(1, 1'b0, 12'h2B5, 2'b11);
        req_valid = 4'b0010;
        run_txn(1, 2, 1'b1, 2'b00, 1'b1, 1'b0);

        // Second read with a different data pattern.
        set_req(3, 1'b1, 12'h0F0, 2'b00);
        req_valid = 4'b1000;
        run_txn(3, 1, 1'b0, 2'b10, 1'b1, 1'b0);

        // Reset while waiting for read data abandons the transaction.
        set_req(2, 1'b1, 12'h801, 2'b00);
        req_valid = 4'b0100;
        run_txn(2, 1, 1'b0, 2'b11, 1'b1, 1'b1);

        // Pointer restarts from 0 after that reset.
        set_req(2, 1'b0, 12'h800, 2'b01);
        set_req(3, 1'b0, 12'h0C3, 2'b10);
        req_valid = 4'b1100;
        run_txn(2, 1, 1'b0, 2'b00, 1'b1, 1'b0);
        run_txn(3, 1, 1'b0, 2'b00, 1'b1, 1'b0);
        req_valid = '0;

        // Requesters 1 and 3 share a row, requester 0 does not.
        set_req(0, 1'b0, 12'h045, 2'b00);
        set_req(1, 1'b0, 12'h3A4, 2'b01);
        set_req(3, 1'b0, 12'h3A7, 2'b11);
        req_valid = 4'b0010;
        run_txn(1, 1, 1'b0, 2'b00, 1'b1, 1'b0);
        req_valid = 4'b1011;
        for (int i = 0; i < 5; i++) run_txn(hit_order[i], 1, 1'b0, 2'b00, 1'b0, 1'b0);
        req_valid = '0;

        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_req_arbiter.md
DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports (2..8).
REQ-002 Parameter U_ADDR_WIDTH, default 12: user address width, format <bank_id[3], row[7], col[2]>.
REQ-003 Parameter U_DATA_WIDTH, default 2: user data width.
REQ-004 u_clk  input  1: single clock; all logic on rising edge.
REQ-005 u_rst  input  1: reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ: per-requester request, held until req_ack.
REQ-007 req_cmd  input  NUM_REQ: per-requester command, 1 = write, 0 = read.
REQ-008 req_addr  input  NUM_REQ*U_ADDR_WIDTH: packed addresses; requester i at slice [i*U_ADDR_WIDTH +: U_ADDR_WIDTH].
REQ-009 req_wdata  input  NUM_REQ*U_DATA_WIDTH: packed write data, same slicing.
REQ-010 req_ack  output  NUM_REQ: one-hot, one-cycle pulse when the request is latched.
REQ-011 req_done  output  NUM_REQ: one-hot, one-cycle pulse on completion (write finished or read data returned).
REQ-012 req_rdata  output  U_DATA_WIDTH: read data, valid only while the matching req_done bit is high.
REQ-013 arb_busy  output  1: high in every state except ARB_IDLE.
REQ-014 ctrl_en, ctrl_cmd  output  1 each: controller enable and command.
REQ-015 ctrl_addr  output  U_ADDR_WIDTH; ctrl_wdata  output  U_DATA_WIDTH: latched winner address and data.
REQ-016 ctrl_busy, ctrl_data_valid, ctrl_refresh_done  input  1 each: controller busy, read-valid pulse, refresh-complete pulse.
REQ-017 ctrl_data_o  input  U_DATA_WIDTH: controller read data.

Function
REQ-018 FSM states: ARB_IDLE, ARB_ISSUE, ARB_EXEC, ARB_RDWAIT.
REQ-019 ARB_IDLE: when any req_valid and ctrl_busy==0, select a winner, latch its cmd/addr/wdata, pulse its req_ack, and go to ARB_ISSUE. If ctrl_busy==1 (e.g. boot refresh), no grant.
REQ-020 Base selection: round-robin from pointer rr_ptr. The first asserted req_valid at index rr_ptr, rr_ptr+1, ... mod NUM_REQ wins. After a grant, rr_ptr = winner+1 mod NUM_REQ.
REQ-021 ARB_ISSUE: ctrl_en=1, ctrl_* stable; go to ARB_EXEC when ctrl_busy==1.
REQ-022 ARB_EXEC: ctrl_en=1 while ctrl_busy==1; when ctrl_busy==0, ctrl_en=0 in that same cycle (combinational).
  - Write: pulse req_done[winner] that cycle, go to ARB_IDLE.
  - Read: go to ARB_RDWAIT.
REQ-023 ctrl_refresh_done==1 in ARB_ISSUE or ARB_EXEC means the busy period was a refresh, not the command. Go to (or stay in) ARB_ISSUE with ctrl_en=1 and the same latched command, so it is re-issued. No req_done.
REQ-024 ARB_RDWAIT: ctrl_en=0. On ctrl_data_valid, register ctrl_data_o to req_rdata and pulse req_done[winner] in the next cycle, then go to ARB_IDLE. Nominal read latency: req_done 2 cycles after ctrl_busy falls.
REQ-025 Exactly one outstanding transaction. req_valid changes on non-winners while not in ARB_IDLE are ignored.
REQ-026 req_ack and req_done never assert in the same cycle for the same requester. A requester whose req_done pulses in ARB_RDWAIT→ARB_IDLE is eligible again in the following ARB_IDLE cycle.

Reset
REQ-027 On u_rst: state=ARB_IDLE, rr_ptr=0, req_ack=0, req_done=0, req_rdata=0, ctrl_en=0, ctrl_cmd=0, ctrl_addr=0, ctrl_wdata=0, arb_busy=0, hit_cnt=0, last bank/row=0 with valid flag cleared.
REQ-028 Reset mid-transaction abandons the transaction with no req_done. Reset takes priority over every other event in that cycle.

Configuration
REQ-029 Macro ARB_ROW_HIT_PRIO_EN defined:
  - ARB_IDLE first searches, in round-robin order from rr_ptr, for a requester whose bank and row equal the last issued bank and row (last-valid flag set). Such a requester wins while hit_cnt<4.
  - hit_cnt increments on each row-hit grant and clears on any non-hit grant.
  - At hit_cnt==4, plain round-robin applies for that grant.
REQ-030 Macro not defined: pure round-robin. No last-address or hit_cnt storage is synthesized.

Verification
REQ-031 Reset, then req_valid=4'b0001 write to addr 0x045 with data 2'b10, ctrl_busy high 3 cycles -> req_ack[0] at grant; ctrl_addr=0x045, ctrl_wdata=2'b10; req_done[0] in the cycle ctrl_busy falls.
REQ-032 req_valid=4'b1111 held, rr_ptr=0, macro off -> grant order 0,1,2,3,0.
REQ-033 Read from requester 2, ctrl_data_valid with ctrl_data_o=2'b01 one cycle after busy falls -> req_done[2]=1 and req_rdata=2'b01 the next cycle.
REQ-034 ctrl_refresh_done pulses during ARB_EXEC -> returns to ARB_ISSUE with ctrl_en=1 and the same address; no req_done until the second busy period ends.
REQ-035 Macro on, requesters 1 and 3 repeatedly hitting the last row, requester 0 on another row -> at most 4 consecutive hit grants, then requester 0 is granted.
REQ-036 u_rst asserted in ARB_RDWAIT -> next cycle all outputs at reset values; no req_done.
